load_store_unit: RTL

//   CPU-side initiator for the word-addressed data memory (datamemory: din, ADDR, Clk, WR_RD, dout).
//   - Converts MEM-stage byte-addressed requests into word transactions on that memory.
//   - Requests: LW/LH/LHU/LB/LBU/SW/SH/SB.
//   - Sub-word loads are extracted and extended.
//   - Sub-word stores run a read-modify-write sequence.
//   - Sits between the MIPS pipeline MEM stage and datamemory; stalls the pipeline via busy.

---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide synchronous data memory.
// Sub-word loads are extracted and extended; sub-word stores are read-modify-write.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_ADDR,
  output logic [31:0]       mem_din,
  output logic              mem_WR_RD,
  input  logic [31:0]       mem_dout
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WRITE, S_DONE} state_t;

  function automatic logic [31:0] extract(input logic [2:0] o, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? w[31:16] : w[15:0];
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (o)
      OP_LH:   extract = {{16{h[15]}}, h};
      OP_LHU:  extract = {16'd0, h};
      OP_LB:   extract = {{24{b[7]}}, b};
      OP_LBU:  extract = {24'd0, b};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] o, input logic [1:0] off,
                                        input logic [31:0] w, input logic [31:0] d);
    if (o == OP_SH) begin
      merge = off[1] ? {d[15:0], w[15:0]} : {w[31:16], d[15:0]};
    end else if (o == OP_SB) begin
      case (off)
        2'd0:    merge = {w[31:8], d[7:0]};
        2'd1:    merge = {w[31:16], d[7:0], w[7:0]};
        2'd2:    merge = {w[31:24], d[7:0], w[15:0]};
        default: merge = {d[7:0], w[23:0]};
      endcase
    end else begin
      merge = d;
    end
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          off_q, off_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                bad_q, bad_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_din_q, mem_din_d;
  logic                mem_wr_q, mem_wr_d;
  logic                misalign_s;
  logic                range_s;

  assign misalign_s = (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'd0)) ||
                      (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0]);
  assign range_s    = (addr >> (ADDR_W + 2)) != 32'd0;

  // Status outputs trail the state by one register so every port comes straight off a flop.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    bad_d      = bad_q;
    word_d     = word_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    done_d     = (state_q == S_DONE);
    err_d      = (state_q == S_DONE) && bad_q;
    busy_d     = (state_q != S_IDLE);
    mem_wr_d   = (state_q == S_WRITE);
    if ((state_q == S_DONE) && !bad_q && (op_q <= OP_LBU)) begin
      rdata_d = extract(op_q, off_q, word_q);
    end else begin
      rdata_d = rdata_q;
    end
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = op;
          off_d   = addr[1:0];
          wdata_d = wdata;
          bad_d   = misalign_s || range_s;
          if (misalign_s || range_s) begin
            state_d = S_DONE;
          end else begin
            mem_addr_d = addr[ADDR_W+1:2];
            if (op == OP_SW) begin
              mem_din_d = wdata;
              state_d   = S_WRITE;
            end else begin
              state_d = S_RD;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD:    state_d = S_CAP;
      S_CAP: begin
        if (op_q <= OP_LBU) begin
          word_d  = mem_dout;
          state_d = S_DONE;
        end else begin
          mem_din_d = merge(op_q, off_q, mem_dout, wdata_q);
          state_d   = S_WRITE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latches and registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      off_q      <= 2'd0;
      wdata_q    <= 32'd0;
      bad_q      <= 1'b0;
      word_q     <= 32'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= 32'd0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      bad_q      <= bad_d;
      word_q     <= word_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_ADDR  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_WR_RD = mem_wr_q;

endmodule
